// File: rtl/motor_wb_arbiter_pkg.sv
// rtl/motor_wb_arbiter_pkg.sv - shared types and helpers for the motor register-port arbiter
package motor_wb_arbiter_pkg;

   localparam int DEF_ADR_W = 12;
   localparam int DEF_DAT_W = 32;

   typedef enum logic [1:0] {
      IDLE,
      XFER,
      RESP
   } state_t;

   // Bits needed to count 0..tmo-1 cycles spent waiting for the motor ack.
   function automatic int tmo_cnt_width(input int tmo);
      return (tmo < 2) ? 1 : $clog2(tmo);
   endfunction

endpackage

// File: rtl/motor_wb_arbiter_rr_arbiter.sv
// rtl/motor_wb_arbiter_rr_arbiter.sv - combinational round-robin picker: first request at or after ptr
module rr_arbiter
   import motor_wb_arbiter_pkg::*;
#(
   parameter int NREQ = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [1:0]      ptr,
   output logic [NREQ-1:0] gnt,
   output logic [1:0]      gnt_idx
);

   // Distance from ptr (modulo NREQ) ranks the candidates; the smallest asserted one wins.
   always_comb begin
      int best;
      best    = NREQ;
      gnt     = '0;
      gnt_idx = '0;
      for (int j = 0; j < NREQ; j++) begin
         if (req[j] && (((j + 4 * NREQ - int'(ptr)) % NREQ) < best)) begin
            best    = (j + 4 * NREQ - int'(ptr)) % NREQ;
            gnt     = '0;
            gnt[j]  = 1'b1;
            gnt_idx = 2'(j);
         end
      end
   end

endmodule

// File: rtl/motor_wb_arbiter.sv
// rtl/motor_wb_arbiter.sv - shares the motor register port between NREQ requesters
// Round-robin grant, one transfer per grant, abort with an error pulse if the motor never acks.
module motor_wb_arbiter
   import motor_wb_arbiter_pkg::*;
#(
   parameter int NREQ    = 2,
   parameter int ADR_W   = DEF_ADR_W,
   parameter int DAT_W   = DEF_DAT_W,
   parameter int TMO_CYC = 255
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req_cs_i,
   input  logic [NREQ-1:0]       req_we_i,
   input  logic [NREQ*ADR_W-1:0] req_adr_i,
   input  logic [NREQ*DAT_W-1:0] req_dat_i,
   output logic [NREQ-1:0]       req_ack_o,
   output logic [NREQ-1:0]       req_err_o,
   output logic [DAT_W-1:0]      req_dat_o,
   output logic                  m_wb_cs_o,
   output logic                  m_wb_we_o,
   output logic [ADR_W-1:0]      m_wb_adr_o,
   output logic [DAT_W-1:0]      m_wb_dat_o,
   input  logic                  m_wb_ack_i,
   input  logic [DAT_W-1:0]      m_wb_dat_i,
   output logic                  busy_o,
   output logic [1:0]            owner_o
);

   localparam int CW = tmo_cnt_width(TMO_CYC);
   localparam logic [CW-1:0] CNT_LAST = CW'(TMO_CYC - 1);

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q;
   logic [1:0]        ptr_q;
   logic [1:0]        next_ptr;
   logic [NREQ-1:0]   owner_oh_q;
   logic [NREQ-1:0]   gnt;
   logic [1:0]        gnt_idx;
   logic              sel_we;
   logic [ADR_W-1:0]  sel_adr;
   logic [DAT_W-1:0]  sel_dat;
   logic              expired;

   rr_arbiter #(.NREQ(NREQ)) u_rr (
      .req     (req_cs_i),
      .ptr     (ptr_q),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   always_comb begin
      sel_we  = 1'b0;
      sel_adr = '0;
      sel_dat = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (gnt[k]) begin
            sel_we  = req_we_i[k];
            sel_adr = req_adr_i[k*ADR_W +: ADR_W];
            sel_dat = req_dat_i[k*DAT_W +: DAT_W];
         end
      end
   end

   assign expired  = (cnt_q == CNT_LAST);
   assign next_ptr = (owner_o == 2'(NREQ - 1)) ? 2'd0 : owner_o + 2'd1;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (|req_cs_i) state_d = XFER;
         XFER:    if (m_wb_ack_i || expired) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         ptr_q      <= '0;
         owner_oh_q <= '0;
         owner_o    <= '0;
         busy_o     <= 1'b0;
         m_wb_cs_o  <= 1'b0;
         m_wb_we_o  <= 1'b0;
         m_wb_adr_o <= '0;
         m_wb_dat_o <= '0;
         req_dat_o  <= '0;
         req_ack_o  <= '0;
         req_err_o  <= '0;
      end else begin
         state_q   <= state_d;
         busy_o    <= (state_d != IDLE);
         req_ack_o <= '0;
         req_err_o <= '0;
         case (state_q)
            IDLE: begin
               if (|req_cs_i) begin
                  owner_o    <= gnt_idx;
                  owner_oh_q <= gnt;
                  m_wb_cs_o  <= 1'b1;
                  m_wb_we_o  <= sel_we;
                  m_wb_adr_o <= sel_adr;
                  m_wb_dat_o <= sel_dat;
                  cnt_q      <= '0;
               end
            end
            XFER: begin
               // A late ack on the expiry cycle still completes the transfer normally.
               if (m_wb_ack_i) begin
                  req_dat_o <= m_wb_dat_i;
                  m_wb_cs_o <= 1'b0;
                  req_ack_o <= owner_oh_q;
               end else if (expired) begin
                  req_dat_o <= '0;
                  m_wb_cs_o <= 1'b0;
                  req_err_o <= owner_oh_q;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RESP: begin
               ptr_q <= next_ptr;
               cnt_q <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_motor_wb_arbiter.sv
// tb/tb_motor_wb_arbiter.sv - scoreboard bench for motor_wb_arbiter with a motor responder model
module tb_motor_wb_arbiter;

   localparam int NREQ  = 3;
   localparam int ADR_W = 12;
   localparam int DAT_W = 32;
   localparam int TMO   = 8;

   typedef struct packed {
      logic        err;
      logic [31:0] dat;
   } exp_t;

   logic                  clock = 1'b0;
   logic                  reset = 1'b0;
   logic [NREQ-1:0]       req_cs_i, req_we_i;
   logic [NREQ*ADR_W-1:0] req_adr_i;
   logic [NREQ*DAT_W-1:0] req_dat_i;
   logic [NREQ-1:0]       req_ack_o, req_err_o;
   logic [DAT_W-1:0]      req_dat_o;
   logic                  m_wb_cs_o, m_wb_we_o;
   logic [ADR_W-1:0]      m_wb_adr_o;
   logic [DAT_W-1:0]      m_wb_dat_o;
   logic                  m_wb_ack_i = 1'b0;
   logic [DAT_W-1:0]      m_wb_dat_i = '0;
   logic                  busy_o;
   logic [1:0]            owner_o;

   logic             r_cs [NREQ];
   logic             r_we [NREQ];
   logic [ADR_W-1:0] r_adr[NREQ];
   logic [DAT_W-1:0] r_dat[NREQ];

   int   n_checks = 0;
   int   n_pass   = 0;
   int   done_cnt = 0;
   logic spur     = 1'b0;
   exp_t exp_q[NREQ][$];
   logic [31:0] shadow[logic [11:0]];
   int   grant_log[$];

   always #5 clock = ~clock;

   always_comb begin
      for (int k = 0; k < NREQ; k++) begin
         req_cs_i[k]                  = r_cs[k];
         req_we_i[k]                  = r_we[k];
         req_adr_i[k*ADR_W +: ADR_W]  = r_adr[k];
         req_dat_i[k*DAT_W +: DAT_W]  = r_dat[k];
      end
   end

   motor_wb_arbiter #(.NREQ(NREQ), .ADR_W(ADR_W), .DAT_W(DAT_W), .TMO_CYC(TMO)) dut (
      .clock(clock), .reset(reset),
      .req_cs_i(req_cs_i), .req_we_i(req_we_i), .req_adr_i(req_adr_i), .req_dat_i(req_dat_i),
      .req_ack_o(req_ack_o), .req_err_o(req_err_o), .req_dat_o(req_dat_o),
      .m_wb_cs_o(m_wb_cs_o), .m_wb_we_o(m_wb_we_o), .m_wb_adr_o(m_wb_adr_o), .m_wb_dat_o(m_wb_dat_o),
      .m_wb_ack_i(m_wb_ack_i), .m_wb_dat_i(m_wb_dat_i),
      .busy_o(busy_o), .owner_o(owner_o)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Motor register contents before any write; address 0x004 holds the canonical test word.
   function automatic logic [31:0] init_val(input logic [11:0] a);
      return (a == 12'h004) ? 32'hDEADBEEF : {20'hC0DE0, a};
   endfunction

   function automatic logic [31:0] wr_reply(input logic [31:0] d);
      return d ^ 32'hFFFF0000;
   endfunction

   // Motor ack latency in cycles of cs: nibble F never acks, E acks on the last allowed cycle.
   function automatic int motor_lat(input logic [11:0] a);
      if (a[3:0] == 4'hF) return 0;
      if (a[3:0] == 4'hE) return TMO - 1;
      return int'(a[1:0]) + 1;
   endfunction

   // Motor responder
   logic [31:0] wmem [4096];
   logic        wvld [4096];
   int          lat_cnt = 0;
   always @(posedge clock) begin
      if (!reset) begin
         m_wb_ack_i <= 1'b0;
         lat_cnt    <= 0;
      end else if (spur) begin
         m_wb_ack_i <= 1'b1;
      end else if (m_wb_cs_o && !m_wb_ack_i) begin
         lat_cnt <= lat_cnt + 1;
         if (motor_lat(m_wb_adr_o) == lat_cnt + 1) begin
            m_wb_ack_i <= 1'b1;
            if (m_wb_we_o) begin
               wmem[m_wb_adr_o] <= m_wb_dat_o;
               wvld[m_wb_adr_o] <= 1'b1;
               m_wb_dat_i       <= wr_reply(m_wb_dat_o);
            end else begin
               m_wb_dat_i <= (wvld[m_wb_adr_o] === 1'b1) ? wmem[m_wb_adr_o] : init_val(m_wb_adr_o);
            end
         end
      end else begin
         m_wb_ack_i <= 1'b0;
         lat_cnt    <= 0;
      end
   end

   // Response monitor: pops the requester's expected response whenever it pulses ack/err.
   exp_t e_pop;
   always @(negedge clock) begin
      if (reset) begin
         for (int k = 0; k < NREQ; k++) begin
            if (req_ack_o[k] || req_err_o[k]) begin
               chk($sformatf("rsp%0d_ack_and_err", k), 64'(req_ack_o[k] & req_err_o[k]), 0);
               chk($sformatf("rsp%0d_expected", k), 64'(exp_q[k].size() > 0), 1);
               if (exp_q[k].size() > 0) begin
                  e_pop = exp_q[k].pop_front();
                  chk($sformatf("rsp%0d_err", k), 64'(req_err_o[k]), 64'(e_pop.err));
                  chk($sformatf("rsp%0d_data", k), 64'(req_dat_o), 64'(e_pop.dat));
               end
            end
         end
      end
   end

   // Grant monitor: predicts the owner from the requests seen at the grant edge.
   logic [NREQ-1:0]       snap_cs;
   logic [NREQ-1:0]       snap_we;
   logic [NREQ*ADR_W-1:0] snap_adr;
   logic [NREQ*DAT_W-1:0] snap_dat;
   always @(posedge clock) begin
      snap_cs  <= req_cs_i;
      snap_we  <= req_we_i;
      snap_adr <= req_adr_i;
      snap_dat <= req_dat_i;
   end

   logic             cs_prev;
   int               model_ptr;
   int               exp_o;
   int               skip[NREQ];
   logic [ADR_W-1:0] g_adr;
   logic [DAT_W-1:0] g_dat;
   always @(negedge clock) begin
      if (!reset) begin
         cs_prev   = 1'b0;
         model_ptr = 0;
         for (int j = 0; j < NREQ; j++) skip[j] = 0;
      end else begin
         if (m_wb_cs_o && !cs_prev) begin
            exp_o = -1;
            for (int d = 0; d < NREQ; d++)
               if (exp_o < 0 && snap_cs[(model_ptr + d) % NREQ]) exp_o = (model_ptr + d) % NREQ;
            chk("grant_owner", 64'(owner_o), 64'(exp_o));
            if (exp_o >= 0) begin
               g_adr = snap_adr[exp_o*ADR_W +: ADR_W];
               g_dat = snap_dat[exp_o*DAT_W +: DAT_W];
               chk("grant_adr", 64'(m_wb_adr_o), 64'(g_adr));
               chk("grant_dat", 64'(m_wb_dat_o), 64'(g_dat));
               chk("grant_we", 64'(m_wb_we_o), 64'(snap_we[exp_o]));
               chk("fair_wait", 64'(skip[exp_o] <= NREQ - 1), 1);
               for (int j = 0; j < NREQ; j++)
                  if (j == exp_o) skip[j] = 0;
                  else if (snap_cs[j]) skip[j]++;
               grant_log.push_back(exp_o);
               model_ptr = (exp_o + 1) % NREQ;
            end
         end else if (m_wb_cs_o) begin
            chk("hold_adr", 64'(m_wb_adr_o), 64'(g_adr));
            chk("hold_dat", 64'(m_wb_dat_o), 64'(g_dat));
         end
         cs_prev = m_wb_cs_o;
      end
   end

   task automatic do_req(input int k, input logic we, input logic [11:0] adr, input logic [31:0] dat,
                         input bit scramble, output int t_cs, output int t_rsp, output int n_cs,
                         output logic [31:0] rdat, output logic got_err);
      exp_t e;
      e.err = (adr[3:0] == 4'hF);
      if (e.err)   e.dat = '0;
      else if (we) e.dat = wr_reply(dat);
      else         e.dat = shadow.exists(adr) ? shadow[adr] : init_val(adr);
      if (we && !e.err) shadow[adr] = dat;
      exp_q[k].push_back(e);
      @(posedge clock); #1;
      r_cs[k] = 1'b1; r_we[k] = we; r_adr[k] = adr; r_dat[k] = dat;
      t_cs = -1; t_rsp = -1; n_cs = 0; rdat = '0; got_err = 1'b0;
      for (int n = 0; n < 200; n++) begin
         @(negedge clock);
         if (m_wb_cs_o && owner_o == 2'(k)) begin
            n_cs++;
            if (t_cs < 0) t_cs = n;
            if (scramble) begin
               r_adr[k] = 12'($urandom);
               r_dat[k] = $urandom;
            end
         end
         if (req_ack_o[k] || req_err_o[k]) begin
            t_rsp   = n;
            rdat    = req_dat_o;
            got_err = req_err_o[k];
            break;
         end
      end
      r_cs[k] = 1'b0;
      chk($sformatf("req%0d_response_seen", k), 64'(t_rsp >= 0), 1);
   endtask

   task automatic req_simple(input int k, input logic we, input logic [11:0] adr, input logic [31:0] dat,
                             input bit scramble);
      int a, b, c;
      logic [31:0] d;
      logic er;
      do_req(k, we, adr, dat, scramble, a, b, c, d, er);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   int          t_cs, t_rsp, n_cs;
   logic [31:0] rd;
   logic        er;
   initial begin
      for (int k = 0; k < NREQ; k++) begin
         r_cs[k] = 1'b0; r_we[k] = 1'b0; r_adr[k] = '0; r_dat[k] = '0;
      end
      reset = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_cs", 64'(m_wb_cs_o), 0);
      chk("rst_busy", 64'(busy_o), 0);
      chk("rst_owner", 64'(owner_o), 0);
      chk("rst_ack", 64'(req_ack_o), 0);
      chk("rst_err", 64'(req_err_o), 0);
      chk("rst_rdat", 64'(req_dat_o), 0);
      chk("rst_madr", 64'(m_wb_adr_o), 0);
      @(posedge clock); #1 reset = 1'b1;

      do_req(0, 1'b0, 12'h004, 32'h0, 1'b0, t_cs, t_rsp, n_cs, rd, er);
      chk("single_cs_cycle", 64'(t_cs), 1);
      chk("single_ack_cycle", 64'(t_rsp), 3);
      chk("single_data", 64'(rd), 64'h0000_0000_DEAD_BEEF);
      chk("single_err", 64'(er), 0);

      do_req(0, 1'b0, 12'h00F, 32'h0, 1'b0, t_cs, t_rsp, n_cs, rd, er);
      chk("tmo_cs_cycles", 64'(n_cs), TMO);
      chk("tmo_rsp_cycle", 64'(t_rsp), TMO + 1);
      chk("tmo_err", 64'(er), 1);
      chk("tmo_data", 64'(rd), 0);

      do_req(0, 1'b1, 12'h00E, 32'h12345678, 1'b1, t_cs, t_rsp, n_cs, rd, er);
      chk("edge_cs_cycles", 64'(n_cs), TMO);
      chk("edge_rsp_cycle", 64'(t_rsp), TMO + 1);
      chk("edge_err", 64'(er), 0);
      chk("edge_wr_reply", 64'(rd), 64'h0000_0000_EDCB_5678);
      do_req(0, 1'b0, 12'h00E, 32'h0, 1'b0, t_cs, t_rsp, n_cs, rd, er);
      chk("edge_readback", 64'(rd), 64'h0000_0000_1234_5678);

      // Reset while requester 1 is mid-transfer on a never-acking address.
      @(posedge clock); #1;
      r_cs[1] = 1'b1; r_we[1] = 1'b0; r_adr[1] = 12'h40F; r_dat[1] = '0;
      for (int n = 0; n < 10 && !m_wb_cs_o; n++) @(negedge clock);
      chk("rst_mid_xfer_started", 64'(m_wb_cs_o), 1);
      repeat (2) @(negedge clock);
      reset   = 1'b0;
      r_cs[1] = 1'b0;
      @(negedge clock);
      chk("rst_mid_cs", 64'(m_wb_cs_o), 0);
      chk("rst_mid_busy", 64'(busy_o), 0);
      chk("rst_mid_rsp", 64'({req_ack_o, req_err_o}), 0);
      @(posedge clock); #1 reset = 1'b1;

      grant_log.delete();
      fork
         req_simple(0, 1'b0, 12'h020, 32'h0, 1'b0);
         req_simple(1, 1'b0, 12'h404, 32'h0, 1'b0);
      join
      chk("contend_count", 64'(grant_log.size()), 2);
      if (grant_log.size() == 2) begin
         chk("contend_first", 64'(grant_log[0]), 0);
         chk("contend_second", 64'(grant_log[1]), 1);
      end

      grant_log.delete();
      fork
         repeat (3) req_simple(0, 1'b1, 12'h031, $urandom, 1'b1);
         repeat (3) req_simple(1, 1'b1, 12'h432, $urandom, 1'b1);
      join
      chk("alt_count", 64'(grant_log.size()), 6);
      for (int i = 0; i < grant_log.size(); i++)
         chk($sformatf("alt_grant%0d", i), 64'(grant_log[i]), 64'(i % 2));

      for (int k = 0; k < NREQ; k++) begin
         fork
            automatic int kk = k;
            begin
               repeat (30) begin
                  repeat ($urandom_range(0, 3)) @(posedge clock);
                  req_simple(kk, 1'($urandom_range(0, 1)), {2'(kk), 10'($urandom)}, $urandom, 1'b1);
               end
               done_cnt++;
            end
         join_none
      end
      for (int t = 0; t < 20000 && done_cnt < NREQ; t++) @(posedge clock);
      chk("rand_done", 64'(done_cnt), NREQ);

      repeat (3) @(posedge clock);
      #1 spur = 1'b1;
      repeat (4) begin
         @(negedge clock);
         chk("spur_busy", 64'(busy_o), 0);
         chk("spur_cs", 64'(m_wb_cs_o), 0);
         chk("spur_rsp", 64'({req_ack_o, req_err_o}), 0);
      end
      @(posedge clock); #1 spur = 1'b0;
      repeat (2) @(posedge clock);
      do_req(2, 1'b0, 12'h804, 32'h0, 1'b0, t_cs, t_rsp, n_cs, rd, er);
      chk("post_spur_ack_cycle", 64'(t_rsp), 3);

      repeat (3) @(posedge clock);
      for (int k = 0; k < NREQ; k++) chk($sformatf("drain%0d", k), 64'(exp_q[k].size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
